// File: rtl/utm_step_engine_if.sv
// Handshake bundle between the tape-read path, the step engine and the
// tape-write/head-move path.
//   sym_in / sym_in_valid / sym_in_ready : symbol under the head, into the engine
//   out_valid / out_ready                : transition result handshake
//   new_sym / direction / encoded_next_state : transition result payload
// Modports: slave = engine view, master = tape controller view.
interface utm_step_engine_if #(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned STATE_W = 3
);
  logic [SYM_W-1:0]   sym_in;
  logic               sym_in_valid;
  logic               sym_in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [SYM_W-1:0]   new_sym;
  logic               direction;
  logic [STATE_W-1:0] encoded_next_state;

  modport slave (
    input  sym_in, sym_in_valid, out_ready,
    output sym_in_ready, out_valid, new_sym, direction, encoded_next_state
  );

  modport master (
    output sym_in, sym_in_valid, out_ready,
    input  sym_in_ready, out_valid, new_sym, direction, encoded_next_state
  );
endinterface

// File: rtl/utm_step_engine.sv
// Turing-machine step engine: one transition per accepted tape symbol, using a
// runtime-programmable transition table indexed by {state, symbol}.
// Ports:
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   mode                    : 1 = use internal cur_state, 0 = use state_in
//   restart                 : synchronous return to idle with START_STATE
//   cfg_we/cfg_addr/cfg_data: table write port, entry = {new_sym, direction, next_state}
//   state_in                : external state (mode 0)
//   bus (slave)             : symbol input and result output handshakes
//   cur_state, halted, step_count : machine status
module utm_step_engine #(
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned STATE_W     = 3,
  parameter int unsigned START_STATE = 0,
  parameter int unsigned HALT_STATE  = (1 << STATE_W) - 1,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       mode,
  input  logic                       restart,
  input  logic                       cfg_we,
  input  logic [STATE_W+SYM_W-1:0]   cfg_addr,
  input  logic [SYM_W+STATE_W:0]     cfg_data,
  input  logic [STATE_W-1:0]         state_in,
  utm_step_engine_if.slave           bus,
  output logic [STATE_W-1:0]         cur_state,
  output logic                       halted,
  output logic [COUNT_W-1:0]         step_count
);

  localparam int unsigned ADDR_W  = STATE_W + SYM_W;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned ENTRY_W = SYM_W + 1 + STATE_W;

  localparam logic [STATE_W-1:0] START_ST = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] HALT_ST  = STATE_W'(HALT_STATE);

  typedef enum logic [1:0] {StIdle, StLookup, StEmit, StHalt} fsm_e;

  fsm_e               fsm_q;
  logic [ENTRY_W-1:0] table_mem [DEPTH];
  logic [ADDR_W-1:0]  addr_q;
  logic               sym_in_ready_q;
  logic               out_valid_q;
  logic [SYM_W-1:0]   new_sym_q;
  logic               direction_q;
  logic [STATE_W-1:0] next_q;
  logic [STATE_W-1:0] cur_state_q;
  logic               halted_q;
  logic [COUNT_W-1:0] count_q;
  logic               cfg_ok;

  assign bus.sym_in_ready       = sym_in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.new_sym            = new_sym_q;
  assign bus.direction          = direction_q;
  assign bus.encoded_next_state = next_q;
  assign cur_state              = cur_state_q;
  assign halted                 = halted_q;
  assign step_count             = count_q;

  // Writes are dropped while a lookup/result is in flight so the presented
  // result never disagrees with the table.
  assign cfg_ok = (fsm_q == StIdle) || (fsm_q == StHalt);

  // Table is deliberately not reset: it survives reset_n and restart.
  always_ff @(posedge clock) begin
    if (cfg_we && cfg_ok) begin
      table_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q          <= StIdle;
      addr_q         <= '0;
      sym_in_ready_q <= 1'b1;
      out_valid_q    <= 1'b0;
      new_sym_q      <= '0;
      direction_q    <= 1'b0;
      next_q         <= '0;
      cur_state_q    <= START_ST;
      halted_q       <= 1'b0;
      count_q        <= '0;
    end else if (restart) begin
      // Overrides any handshake in the same cycle; a pending result is lost.
      fsm_q          <= StIdle;
      sym_in_ready_q <= 1'b1;
      out_valid_q    <= 1'b0;
      cur_state_q    <= START_ST;
      halted_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (bus.sym_in_valid) begin
            addr_q         <= {(mode ? cur_state_q : state_in), bus.sym_in};
            sym_in_ready_q <= 1'b0;
            fsm_q          <= StLookup;
          end
        end
        StLookup: begin
          // A write in the accept cycle has already committed by this edge.
          {new_sym_q, direction_q, next_q} <= table_mem[addr_q];
          out_valid_q <= 1'b1;
          fsm_q       <= StEmit;
        end
        StEmit: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cur_state_q <= next_q;
            if (count_q != {COUNT_W{1'b1}}) begin
              count_q <= count_q + 1'b1;
            end
            if (next_q == HALT_ST) begin
              halted_q <= 1'b1;
              fsm_q    <= StHalt;
            end else begin
              sym_in_ready_q <= 1'b1;
              fsm_q          <= StIdle;
            end
          end
        end
        StHalt: begin
          // Only restart or reset leave this state.
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_utm_step_engine.sv
// Bench for utm_step_engine: default-parameter instance plus a COUNT_W = 2
// instance fed from the same stimulus, checked against a table/state model
// with an expected-result queue.
module tb_utm_step_engine;

  logic        clock;
  logic        reset_n;
  logic        mode;
  logic        restart;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [6:0]  cfg_data;
  logic [2:0]  state_in;
  logic [2:0]  cur_state, cur_state2;
  logic        halted, halted2;
  logic [15:0] step_count;
  logic [1:0]  step_count2;

  utm_step_engine_if #(.SYM_W(3), .STATE_W(3)) bus ();
  utm_step_engine_if #(.SYM_W(3), .STATE_W(3)) bus2 ();

  assign bus2.sym_in       = bus.sym_in;
  assign bus2.sym_in_valid = bus.sym_in_valid;
  assign bus2.out_ready    = bus.out_ready;

  utm_step_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mode       (mode),
    .restart    (restart),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .state_in   (state_in),
    .bus        (bus),
    .cur_state  (cur_state),
    .halted     (halted),
    .step_count (step_count)
  );

  utm_step_engine #(.COUNT_W(2)) dut_sat (
    .clock      (clock),
    .reset_n    (reset_n),
    .mode       (mode),
    .restart    (restart),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .state_in   (state_in),
    .bus        (bus2),
    .cur_state  (cur_state2),
    .halted     (halted2),
    .step_count (step_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] sym;
    logic       dir;
    logic [2:0] nxt;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] model_tbl [64];
  logic [2:0] model_cur;
  int         model_cnt;
  logic       model_halted;
  int         total;
  int         bad;

  task automatic cfg_write(input logic [5:0] a, input logic [6:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    model_tbl[a] = d;
  endtask

  // One full transition. emit_wr: attempt a table write during the first hold
  // cycle (must be dropped). same_wr: write in the accept cycle (must be seen).
  task automatic do_step(input logic [2:0] sym, input logic [2:0] st, input int hold,
                         input logic emit_wr, input logic same_wr,
                         input logic [5:0] wa, input logic [6:0] wd);
    logic [5:0] idx;
    logic [6:0] ent;
    logic [1:0] sat;
    exp_t       e;
    int         cyc;
    if (same_wr) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      model_tbl[wa] = wd;
    end
    idx = {(mode ? model_cur : st), sym};
    ent = model_tbl[idx];
    exp_q.push_back(exp_t'(ent));
    state_in = st;
    bus.sym_in = sym;
    bus.sym_in_valid = 1'b1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.sym_in_ready !== 1'b1) begin
      bad++; $display("FAIL idle_ready got %0b want 1", bus.sym_in_ready);
    end
    @(posedge clock); #1;
    bus.sym_in_valid = 1'b0;
    cfg_we = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 8) begin
      @(posedge clock); #1;
      cyc++;
    end
    total++;
    if (cyc !== 1) begin
      bad++; $display("FAIL latency got %0d cycles want 1", cyc);
    end
    e = exp_q.pop_front();
    total++;
    if (bus.new_sym !== e.sym) begin
      bad++; $display("FAIL new_sym got %0h want %0h", bus.new_sym, e.sym);
    end
    total++;
    if (bus.direction !== e.dir) begin
      bad++; $display("FAIL direction got %0h want %0h", bus.direction, e.dir);
    end
    total++;
    if (bus.encoded_next_state !== e.nxt) begin
      bad++; $display("FAIL next_state got %0h want %0h", bus.encoded_next_state, e.nxt);
    end
    for (int i = 0; i < hold; i++) begin
      if (emit_wr && i == 0) begin
        cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      end
      @(posedge clock); #1;
      cfg_we = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.sym_in_ready !== 1'b0 ||
          {bus.new_sym, bus.direction, bus.encoded_next_state} !== e) begin
        bad++;
        $display("FAIL hold_stable got v=%0b r=%0b out=%0h want v=1 r=0 out=%0h",
                 bus.out_valid, bus.sym_in_ready,
                 {bus.new_sym, bus.direction, bus.encoded_next_state}, e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    model_cur = e.nxt;
    if (model_cnt < 65535) model_cnt++;
    model_halted = (e.nxt == 3'd7);
    sat = (model_cnt > 3) ? 2'd3 : 2'(model_cnt);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL post_valid got %0b want 0", bus.out_valid);
    end
    total++;
    if (cur_state !== model_cur) begin
      bad++; $display("FAIL cur_state got %0h want %0h", cur_state, model_cur);
    end
    total++;
    if (step_count !== 16'(model_cnt)) begin
      bad++; $display("FAIL step_count got %0d want %0d", step_count, model_cnt);
    end
    total++;
    if (halted !== model_halted || bus.sym_in_ready !== !model_halted) begin
      bad++; $display("FAIL halt_flags got h=%0b r=%0b want h=%0b r=%0b",
                      halted, bus.sym_in_ready, model_halted, !model_halted);
    end
    total++;
    if (step_count2 !== sat) begin
      bad++; $display("FAIL sat_count got %0d want %0d", step_count2, sat);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.sym_in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hs got r=%0b v=%0b want r=1 v=0",
                      bus.sym_in_ready, bus.out_valid);
    end
    total++;
    if ({bus.new_sym, bus.direction, bus.encoded_next_state} !== 7'd0) begin
      bad++; $display("FAIL reset_out got %0h want 0",
                      {bus.new_sym, bus.direction, bus.encoded_next_state});
    end
    total++;
    if (cur_state !== 3'd0 || halted !== 1'b0 || step_count !== 16'd0) begin
      bad++; $display("FAIL reset_status got cs=%0h h=%0b n=%0d want 0 0 0",
                      cur_state, halted, step_count);
    end
  endtask

  task automatic program_table();
    cfg_write(6'o01, {3'd2, 1'b1, 3'd3});
    cfg_write(6'o31, {3'd4, 1'b0, 3'd0});
    cfg_write(6'o54, {3'd6, 1'b1, 3'd1});
    cfg_write(6'o04, {3'd1, 1'b0, 3'd2});
    cfg_write(6'o13, {3'd2, 1'b0, 3'd0});
    cfg_write(6'o60, {3'd0, 1'b0, 3'd3});
    cfg_write(6'o32, {3'd5, 1'b0, 3'd7});
    cfg_write(6'o00, {3'd1, 1'b1, 3'd0});
  endtask

  task automatic test_basic();
    mode = 1'b1;
    do_step(3'd1, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
  endtask

  task automatic test_backpressure();
    do_step(3'd1, 3'd0, 5, 1'b0, 1'b0, 6'd0, 7'd0);
  endtask

  task automatic test_mode0();
    mode = 1'b0;
    do_step(3'd4, 3'd5, 0, 1'b0, 1'b0, 6'd0, 7'd0);
  endtask

  task automatic test_cfg_timing();
    mode = 1'b1;
    do_step(3'd3, 3'd0, 2, 1'b1, 1'b0, 6'o13, {3'd5, 1'b1, 3'd6});
    mode = 1'b0;
    do_step(3'd3, 3'd1, 0, 1'b0, 1'b0, 6'd0, 7'd0);
    do_step(3'd3, 3'd1, 0, 1'b0, 1'b1, 6'o13, {3'd5, 1'b1, 3'd6});
  endtask

  task automatic test_halt();
    mode = 1'b1;
    do_step(3'd0, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
    do_step(3'd2, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
    bus.sym_in = 3'd1;
    bus.sym_in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++;
      if (bus.out_valid !== 1'b0 || halted !== 1'b1 || step_count !== 16'(model_cnt)) begin
        bad++; $display("FAIL halt_ignore got v=%0b h=%0b n=%0d want v=0 h=1 n=%0d",
                        bus.out_valid, halted, step_count, model_cnt);
      end
    end
    bus.sym_in_valid = 1'b0;
    bus.out_ready = 1'b0;
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
    model_cur = 3'd0; model_cnt = 0; model_halted = 1'b0;
    total++;
    if (cur_state !== 3'd0 || step_count !== 16'd0 || halted !== 1'b0 ||
        bus.sym_in_ready !== 1'b1 || step_count2 !== 2'd0) begin
      bad++; $display("FAIL restart got cs=%0h n=%0d h=%0b r=%0b want 0 0 0 1",
                      cur_state, step_count, halted, bus.sym_in_ready);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      do_step(3'd0, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
    end
    total++;
    if (step_count2 !== 2'd3 || step_count !== 16'd5) begin
      bad++; $display("FAIL saturate got %0d/%0d want 3/5", step_count2, step_count);
    end
  endtask

  task automatic test_reset_mid_emit();
    do_step(3'd1, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
    bus.sym_in = 3'd1;
    bus.sym_in_valid = 1'b1;
    @(posedge clock); #1;
    bus.sym_in_valid = 1'b0;
    @(posedge clock); #1;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_valid got %0b want 1", bus.out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || cur_state !== 3'd0 || step_count !== 16'd0 ||
        bus.sym_in_ready !== 1'b1 || bus.new_sym !== 3'd0) begin
      bad++; $display("FAIL async_reset got v=%0b cs=%0h n=%0d r=%0b s=%0h want 0 0 0 1 0",
                      bus.out_valid, cur_state, step_count, bus.sym_in_ready, bus.new_sym);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_cur = 3'd0; model_cnt = 0; model_halted = 1'b0;
    do_step(3'd1, 3'd0, 0, 1'b0, 1'b0, 6'd0, 7'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    model_cur = 3'd0; model_cnt = 0; model_halted = 1'b0;
    reset_n = 1'b0; mode = 1'b1; restart = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; state_in = '0;
    bus.sym_in = '0; bus.sym_in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset();
    program_table();
    test_basic();
    test_backpressure();
    test_mode0();
    test_cfg_timing();
    test_halt();
    test_saturation();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
